// File: rtl/spi_flash_reader_pkg.sv
// spi_flash_reader_pkg: shared types and constants for the serial flash reader
package spi_flash_reader_pkg;
   typedef enum logic [1:0] {IDLE, XFER, DONE, RELEASE} state_t;
   localparam int XFER_BITS = 40;
   localparam int ADDR_W = 24;
   localparam int DATA_W = 8;
   localparam int DATA_START = XFER_BITS - DATA_W;
   localparam logic [7:0] READ_CMD_DEF = 8'h03;
endpackage

// File: rtl/spi_flash_reader_phase_timer.sv
// spi_phase_timer: one-cycle tick at the end of every CLK_DIV-cycle SCK phase
module spi_phase_timer #(
   parameter int CLK_DIV = 2
) (
   input  logic clk,
   input  logic rstn,
   input  logic en,
   output logic phase_tick
);
   localparam int CW = $clog2(CLK_DIV) + 1;
   logic [CW-1:0] cnt_q, cnt_d;
   assign phase_tick = en && (cnt_q == CW'(CLK_DIV - 1));
   // restart the count at every phase boundary and hold it at zero while idle
   always_comb cnt_d = (!en || phase_tick) ? '0 : cnt_q + 1'b1;
   // phase counter register
   always_ff @(posedge clk) cnt_q <= !rstn ? '0 : cnt_d;
endmodule

// File: rtl/spi_flash_reader.sv
// spi_flash_reader: single-byte SPI mode-0 READ serving the flash-data handshake
module spi_flash_reader
   import spi_flash_reader_pkg::*;
#(
   parameter int CLK_DIV = 2,
   parameter logic [7:0] READ_CMD = READ_CMD_DEF
) (
   input  logic              clk,
   input  logic              rstn,
   input  logic              fd_valid,
   input  logic [ADDR_W-1:0] fd_address,
   output logic              fd_ready,
   output logic [DATA_W-1:0] fd,
   output logic              busy,
   output logic              spi_cs_n,
   output logic              spi_sck,
   output logic              spi_mosi,
   input  logic              spi_miso
);
   state_t                 state_q;
   logic [XFER_BITS-1:0]   sh_q;
   logic [DATA_W-1:0]      rx_q, fd_q;
   logic [5:0]             bit_q;
   logic                   last_q, hold_q, sck_q, cs_n_q, busy_q, rdy_q, tick;
   spi_phase_timer #(.CLK_DIV(CLK_DIV)) u_timer (
      .clk(clk),
      .rstn(rstn),
      .en(state_q == XFER),
      .phase_tick(tick)
   );
   assign fd_ready = rdy_q;
   assign fd       = fd_q;
   assign busy     = busy_q;
   assign spi_cs_n = cs_n_q;
   assign spi_sck  = sck_q;
   assign spi_mosi = sh_q[XFER_BITS-1];
   // transaction FSM: shift out command/address, sample data on high-phase ends, hand back the byte
   always_ff @(posedge clk) begin
      if (!rstn) begin
         state_q <= IDLE;
         sh_q    <= '0;
         rx_q    <= '0;
         fd_q    <= '0;
         bit_q   <= '0;
         last_q  <= 1'b0;
         hold_q  <= 1'b0;
         sck_q   <= 1'b0;
         cs_n_q  <= 1'b1;
         busy_q  <= 1'b0;
         rdy_q   <= 1'b0;
      end else begin
         rdy_q <= 1'b0;
         case (state_q)
            IDLE: if (fd_valid) begin
               sh_q    <= {READ_CMD, fd_address, {DATA_W{1'b0}}};
               rx_q    <= '0;
               bit_q   <= '0;
               last_q  <= 1'b0;
               hold_q  <= 1'b0;
               sck_q   <= 1'b0;
               cs_n_q  <= 1'b0;
               busy_q  <= 1'b1;
               state_q <= XFER;
            end
            XFER: if (tick) begin
               if (sck_q) begin
                  sck_q <= 1'b0;
                  sh_q  <= {sh_q[XFER_BITS-2:0], 1'b0};
                  if (bit_q >= 6'(DATA_START)) rx_q <= {rx_q[DATA_W-2:0], spi_miso};
                  if (bit_q == 6'(XFER_BITS - 1)) last_q <= 1'b1;
                  else bit_q <= bit_q + 6'd1;
               end else if (!last_q) begin
                  sck_q <= 1'b1;
               end else if (!hold_q) begin
                  hold_q <= 1'b1;
               end else begin
                  cs_n_q  <= 1'b1;
                  fd_q    <= rx_q;
                  rdy_q   <= 1'b1;
                  state_q <= DONE;
               end
            end
            DONE: state_q <= RELEASE;
            RELEASE: if (!fd_valid) begin
               busy_q  <= 1'b0;
               state_q <= IDLE;
            end
            default: state_q <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_spi_flash_reader.sv
// tb_spi_flash_reader: directed checks of the SPI flash reader at CLK_DIV=2 and CLK_DIV=1
module tb_spi_flash_reader;
   logic        clk = 1'b0;
   logic        rstn;
   logic [1:0]  valid, rdy, busy, cs_n, sck, mosi;
   logic        miso [2];
   logic [23:0] addr [2];
   logic [7:0]  fd [2];
   logic [7:0]  fdata [2];
   logic [39:0] cap [2];
   int          rel [2];
   int          total [2];
   int          checks = 0;
   int          failures = 0;

   always #5 clk = ~clk;

   for (genvar g = 0; g < 2; g++) begin : g_dut
      spi_flash_reader #(.CLK_DIV(g == 0 ? 2 : 1)) u_dut (
         .clk(clk),
         .rstn(rstn),
         .fd_valid(valid[g]),
         .fd_address(addr[g]),
         .fd_ready(rdy[g]),
         .fd(fd[g]),
         .busy(busy[g]),
         .spi_cs_n(cs_n[g]),
         .spi_sck(sck[g]),
         .spi_mosi(mosi[g]),
         .spi_miso(miso[g])
      );
      always @(posedge sck[g] or negedge cs_n[g]) begin
         if (!sck[g]) rel[g] = 0;
         else begin
            total[g] = total[g] + 1;
            if (!cs_n[g]) begin
               rel[g] = rel[g] + 1;
               cap[g] = {cap[g][38:0], mosi[g]};
            end
         end
      end
      always @(negedge sck[g]) begin
         if (rel[g] >= 32 && rel[g] < 40) miso[g] = fdata[g][39 - rel[g]];
      end
   end

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic do_read(input int i, input logic [23:0] a, input logic [7:0] d, input bit chg);
      int lat;
      int t0;
      fdata[i] = d;
      addr[i]  = a;
      valid[i] = 1'b1;
      t0 = total[i];
      @(posedge clk); #1;
      chk("busy_on_accept", 64'(busy[i]), 64'd1);
      chk("csn_on_accept", 64'(cs_n[i]), 64'd0);
      lat = 0;
      while (!rdy[i] && lat < 400) begin
         if (chg && lat == 60) addr[i] = 24'hFFFFFF;
         @(posedge clk); #1;
         lat++;
      end
      chk("latency", 64'(lat), 64'(i == 0 ? 164 : 82));
      chk("fd_value", 64'(fd[i]), 64'(d));
      chk("mosi_cmd_addr", 64'(cap[i][39:8]), {32'd0, 8'h03, a});
      chk("mosi_data_zero", 64'(cap[i][7:0]), 64'd0);
      chk("sck_rises", 64'(total[i] - t0), 64'd40);
      chk("csn_at_done", 64'(cs_n[i]), 64'd1);
      @(posedge clk); #1;
      chk("ready_one_cycle", 64'(rdy[i]), 64'd0);
      chk("busy_in_release", 64'(busy[i]), 64'd1);
      valid[i] = 1'b0;
      @(posedge clk); #1;
      chk("busy_idle", 64'(busy[i]), 64'd0);
   endtask

   initial begin
      int t;
      int n;
      int w;
      rstn = 1'b0;
      valid = 2'b11;
      addr[0] = 24'h0;
      addr[1] = 24'h0;
      fdata[0] = 8'h0;
      fdata[1] = 8'h0;
      @(posedge clk); #1;
      t = total[0] + total[1];
      repeat (2) begin @(posedge clk); #1; end
      chk("rst_csn", 64'(cs_n), 64'd3);
      chk("rst_sck", 64'(sck), 64'd0);
      chk("rst_fd", 64'(fd[0]), 64'd0);
      chk("rst_ready", 64'(rdy), 64'd0);
      chk("rst_busy", 64'(busy), 64'd0);
      chk("rst_no_sck", 64'(total[0] + total[1] - t), 64'd0);
      valid = 2'b00;
      rstn = 1'b1;
      @(posedge clk); #1;
      chk("idle_csn", 64'(cs_n), 64'd3);
      do_read(0, 24'h001234, 8'hA5, 1'b0);
      n = 0;
      repeat (50) begin
         @(posedge clk); #1;
         if (fd[0] == 8'hA5 && cs_n[0] && !busy[0] && !rdy[0]) n++;
      end
      chk("idle_hold_fd", 64'(n), 64'd50);
      do_read(0, 24'h001234, 8'h96, 1'b1);
      fdata[0] = 8'h77;
      addr[0] = 24'h001234;
      valid[0] = 1'b1;
      @(posedge clk); #1;
      w = 0;
      while (rel[0] < 20 && w < 1000) begin @(posedge clk); #1; w++; end
      chk("reach_bit20", 64'(rel[0]), 64'd20);
      rstn = 1'b0;
      @(posedge clk); #1;
      chk("midrst_csn", 64'(cs_n[0]), 64'd1);
      chk("midrst_sck", 64'(sck[0]), 64'd0);
      chk("midrst_fd", 64'(fd[0]), 64'd0);
      chk("midrst_busy", 64'(busy[0]), 64'd0);
      rstn = 1'b1;
      valid[0] = 1'b0;
      n = 0;
      repeat (200) begin
         @(posedge clk); #1;
         if (rdy[0] || !cs_n[0]) n++;
      end
      chk("midrst_quiet", 64'(n), 64'd0);
      do_read(0, 24'h00ABCD, 8'h5A, 1'b0);
      do_read(1, 24'h000000, 8'h3C, 1'b0);
      do_read(1, 24'hFFFFFF, 8'hC3, 1'b0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
